// File: rtl/nn_infer_pkg.sv
// Shared types and sizing helpers for the encrypted-NN inference sequencer.
// Default-configuration constants mirror the address looper's build parameters.
package nn_infer_pkg;

    localparam int DEPTH_DEF  = 100;
    localparam int K_DEF      = 502;
    localparam int NN_OUT_DEF = 10;
    localparam int RD_CNT_W   = 17;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_INIT  = 3'd1;
    localparam state_t ST_RUN   = 3'd2;
    localparam state_t ST_DRAIN = 3'd3;
    localparam state_t ST_DONE  = 3'd4;

    typedef struct packed {
        logic       valid;
        logic       first;
        logic       last;
        logic [5:0] nn;
    } tag_t;

    function automatic int half_k(input int k);
        return k / 2;
    endfunction

    function automatic int total_reads(input int depth, input int k, input int nn_out);
        return depth * (k / 2) * nn_out;
    endfunction

    localparam int HALF_K      = half_k(K_DEF);
    localparam int TOTAL_READS = total_reads(DEPTH_DEF, K_DEF, NN_OUT_DEF);

endpackage

// File: rtl/nn_tag_delay.sv
// Fixed RD_LAT-deep delay line for per-read tags, with synchronous flush.
// Latency RD_LAT cycles; shifts every cycle, no back-pressure.
module nn_tag_delay
    import nn_infer_pkg::*;
#(
    parameter int RD_LAT = 2
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic flush_in,
    input  tag_t tag_in,
    output tag_t tag_out,
    output logic any_valid_out
);

    tag_t pipe [RD_LAT];

    always_ff @(posedge clk_in) begin
        if (rst_in || flush_in) begin
            for (int i = 0; i < RD_LAT; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= tag_in;
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign tag_out = pipe[RD_LAT-1];

    always_comb begin
        any_valid_out = 1'b0;
        for (int i = 0; i < RD_LAT; i++) any_valid_out = any_valid_out | pipe[i].valid;
    end

endmodule

// File: rtl/nn_infer_sequencer.sv
// Run controller for nn_addr_looper: paces its steps, turns fresh addresses into BRAM reads.
// Tags reach the accumulator RD_LAT cycles after rd_en_out; acc_ready_in only throttles lp_begin_out.
module nn_infer_sequencer
    import nn_infer_pkg::*;
#(
    parameter int DEPTH  = 100,
    parameter int K      = 502,
    parameter int NN_OUT = 10,
    parameter int RD_LAT = 2
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic        abort_in,
    input  logic        acc_ready_in,
    input  logic        lp_addr_valid_in,
    input  logic        lp_done_in,
    input  logic [5:0]  lp_nn_in,
    input  logic [7:0]  lp_k_in,
    output logic        lp_rst_out,
    output logic        lp_begin_out,
    output logic        rd_en_out,
    output logic        acc_en_out,
    output logic        acc_first_out,
    output logic        acc_last_out,
    output logic [5:0]  acc_nn_out,
    output logic        busy_out,
    output logic        done_out,
    output logic [16:0] rd_count_out
);

    localparam int HK      = half_k(K);
    localparam int TOT     = total_reads(DEPTH, K, NN_OUT);
    localparam int CNT_LIM = (1 << RD_CNT_W) - 1;
    localparam logic [16:0] CNT_MAX = '1;
    localparam logic [16:0] EXP_CNT = 17'((TOT > CNT_LIM) ? CNT_LIM : TOT);

    state_t state, state_nxt;
    logic   step_q;
    logic   in_run;
    logic   flush;
    logic   pipe_busy;
    tag_t   tag_in, tag_out;

    assign in_run = (state == ST_RUN);
    assign flush  = abort_in && (state != ST_IDLE);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_in) state_nxt = ST_INIT;
            ST_INIT:  state_nxt = ST_RUN;
            ST_RUN:   if (lp_done_in) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!pipe_busy) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
        if (flush) state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state  <= ST_IDLE;
            step_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            step_q <= lp_begin_out;
        end
    end

    // The looper repeats its last address while not stepped, so only an address
    // produced by a step taken last cycle (step_q) is a new read.
    assign lp_rst_out   = (state == ST_IDLE) || (state == ST_INIT);
    assign lp_begin_out = in_run && acc_ready_in && !lp_done_in;
    assign rd_en_out    = in_run && lp_addr_valid_in && step_q && !lp_done_in && !abort_in;
    assign busy_out     = (state != ST_IDLE);
    assign done_out     = (state == ST_DONE);

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rd_count_out <= '0;
        end else if ((state == ST_IDLE) && start_in) begin
            rd_count_out <= '0;
        end else if (rd_en_out && (rd_count_out != CNT_MAX)) begin
            rd_count_out <= rd_count_out + 1'b1;
        end
    end

    always_comb begin
        tag_in       = '0;
        tag_in.valid = rd_en_out;
        tag_in.first = (lp_k_in == 8'd0);
        tag_in.last  = (lp_k_in == 8'(HK - 1));
        tag_in.nn    = lp_nn_in;
    end

    nn_tag_delay #(.RD_LAT(RD_LAT)) u_tag_delay (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .flush_in      (flush),
        .tag_in        (tag_in),
        .tag_out       (tag_out),
        .any_valid_out (pipe_busy)
    );

    assign acc_en_out    = tag_out.valid;
    assign acc_first_out = tag_out.valid && tag_out.first;
    assign acc_last_out  = tag_out.valid && tag_out.last;
    assign acc_nn_out    = tag_out.valid ? tag_out.nn : 6'd0;

    a_run_count: assert property (@(posedge clk_in) disable iff (rst_in)
        (state == ST_DONE) |-> (rd_count_out == EXP_CNT));

endmodule

// File: doc/nn_infer_sequencer.md
Name: nn_infer_sequencer

Overview:
- Run controller for the encrypted-NN address generator (nn_addr_looper).
- Starts and restarts the looper and paces its step input (begin_nn) against downstream back-pressure.
- Qualifies its address stream into BRAM read strobes.
- Delays per-read tags (neuron index, first/last-of-dot-product) by the BRAM read latency so the MAC/accumulator sees aligned enables. Signals completion once the read pipeline drains.

Parameters:
- DEPTH, 100, outer loop count (must match looper).
- K, 502, LWE dimension; HALF_K = K/2 inner k count (must match looper).
- NN_OUT, 10, output neurons per step (must match looper).
- RD_LAT, 2, BRAM read latency in cycles (1..4).

Ports:
- clk_in  in  1  system clock
- rst_in  in  1  synchronous active-high reset
- start_in  in  1  pulse: begin inference run (ignored unless IDLE)
- abort_in  in  1  pulse: cancel run, any state
- acc_ready_in  in  1  accumulator can accept a new read this cycle
- lp_addr_valid_in  in  1  looper addr_valid
- lp_done_in  in  1  looper done
- lp_nn_in  in  6  looper nn_out
- lp_k_in  in  8  looper outer_k_out
- lp_rst_out  out  1  reset to looper
- lp_begin_out  out  1  looper begin_nn (step enable)
- rd_en_out  out  1  BRAM read enable (A, nn, b ports share it)
- acc_en_out  out  1  read data valid at accumulator, RD_LAT after rd_en_out
- acc_first_out  out  1  with acc_en_out: k==0, clear accumulator
- acc_last_out  out  1  with acc_en_out: k==HALF_K-1, result complete
- acc_nn_out  out  6  neuron index aligned with acc_en_out
- busy_out  out  1  state != IDLE
- done_out  out  1  one-cycle pulse at end of run
- rd_count_out  out  17  reads issued this run

Behaviour:
- Reset: state=IDLE, lp_rst_out=1, all other outputs 0, tag pipeline cleared, rd_count_out=0.
- States: IDLE, INIT, RUN, DRAIN, DONE.
- IDLE:
  - lp_rst_out=1, lp_begin_out=0.
  - start_in -> INIT, and rd_count_out clears to 0.
- INIT: one cycle; lp_rst_out=1 so the looper starts clean -> RUN.
- RUN:
  - lp_rst_out=0; lp_begin_out = acc_ready_in (combinational).
  - step_q <= lp_begin_out each cycle.
  - rd_en_out = lp_addr_valid_in & step_q & ~lp_done_in, registered-free so it aligns with the looper's registered address.
  - The step_q qualification is mandatory: the looper holds addr_valid high with repeated addresses while begin_nn is low.
  - Bootstrap gaps appear as addr_valid=0 and issue no read.
  - lp_done_in=1 -> DRAIN; lp_begin_out forced 0 from that cycle.
- Tag pipeline: RD_LAT-deep shift register of {valid, first=(lp_k_in==0), last=(lp_k_in==HALF_K-1), nn=lp_nn_in}, loaded with valid=rd_en_out. Its output drives the acc_* ports. It shifts every cycle regardless of acc_ready_in; back-pressure acts only at lp_begin_out.
- rd_count_out increments on each rd_en_out and saturates at 2^17-1.
- DRAIN: wait until no valid entry remains in the pipeline (at most RD_LAT cycles) -> DONE.
- DONE: done_out=1 for one cycle -> IDLE.
- abort_in: in any non-IDLE state the next state is IDLE. Pipeline valids are cleared in the same edge, no done_out is raised, and rd_count_out holds its value. abort_in wins over simultaneous start_in or lp_done_in.
- start_in while busy: ignored.
- Completion check: a full run issues exactly DEPTH*HALF_K*NN_OUT reads.

Decomposition:
- Package nn_infer_pkg:
  - state enum.
  - tag struct {valid, first, last, nn[5:0]}.
  - localparams HALF_K and TOTAL_READS.
- Sub-module nn_tag_delay (parameterised RD_LAT shift register of tag structs with synchronous flush).

Test Plan (DEPTH=2, K=4, NN_OUT=2, RD_LAT=2; looper BOOTSTRAP=2):
- Reset then idle: rst_in 3 cycles -> lp_rst_out=1, busy_out=0, all acc_* 0, rd_count_out=0.
- Full run, acc_ready_in=1: start_in pulse -> exactly 8 rd_en_out. acc_en_out follows each by 2 cycles. acc_first on k=0, acc_last on k=1. One done_out pulse; rd_count_out=8.
- Back-pressure: acc_ready_in toggles 1,0,0,1 repeating -> no duplicate reads despite held addr_valid; still 8 reads, same (nn,k) order as the unstalled run.
- Bootstrap gap: during looper bootstrap (addr_valid=0 for 2+ cycles) -> rd_en_out=0 and acc_en_out gap 2 cycles later; total remains 8.
- Abort mid-run after 3 reads: abort_in -> next cycle IDLE, lp_rst_out=1, no further acc_en_out, no done_out, rd_count_out=3. A new start_in then yields 8 reads and done_out.
- Simultaneous abort_in and lp_done_in -> IDLE, no done_out. start_in during RUN is ignored (read count unchanged).
